lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words needed to enter LOCKED.
REQ-002 SHALL have parameter LOSS_COUNT, default 3: consecutive mismatching words in LOCKED that force return to SEARCH.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_data carries one received generator word this cycle.
REQ-006 SHALL have port in_data  input  8  received LFSR state word.
REQ-007 SHALL have port clr_err  input  1  synchronous clear of err_cnt.
REQ-008 SHALL have port locked  output  1  high while in LOCKED.
REQ-009 SHALL have port err_pulse  output  1  one-cycle pulse per mismatch counted in LOCKED.
REQ-010 SHALL have port err_cnt  output  8  saturating mismatch count.
REQ-011 SHALL have port seg_lo  output  7  7-segment pattern of err_cnt[3:0], bit6..0 = a..g, active-low.
REQ-012 SHALL have port seg_hi  output  7  7-segment pattern of err_cnt[7:4], same encoding.

Function
REQ-013 SHALL define next(x) = {x[0]^x[2]^x[3]^x[4], x[7:1]} for x != 0, and next(0x00) = 0x01.
REQ-014 SHALL implement states SEARCH, SYNC, LOCKED; cycles with in_valid=0 change no state, register or output except err_pulse clearing.
REQ-015 SEARCH: on valid word, ref <= in_data, match_cnt <= 0, go SYNC.
REQ-016 SYNC: in_data == next(ref) -> ref <= in_data, match_cnt+1; on the LOCK_COUNT-th consecutive match go LOCKED, miss_cnt <= 0.
REQ-017 SYNC: mismatch -> ref <= in_data (reseed), match_cnt <= 0, stay SYNC; no error counted.
REQ-018 LOCKED: every valid word, ref <= next(ref) regardless of match, so one corrupted word counts exactly one error.
REQ-019 LOCKED match: miss_cnt <= 0.
REQ-020 LOCKED mismatch: err_cnt saturating +1, err_pulse <= 1 next cycle, miss_cnt+1; when miss_cnt reaches LOSS_COUNT go SEARCH, locked low the following cycle.
REQ-021 err_cnt SHALL saturate at 0xFF, never wrap.
REQ-022 clr_err SHALL set err_cnt to 0 next cycle; with a coincident mismatch, clear wins (err_cnt=0) but err_pulse still asserts.
REQ-023 locked, err_pulse, err_cnt SHALL be registered, updated one cycle after the accepted word; seg_lo/seg_hi SHALL be combinational from err_cnt.
REQ-024 Segment table (active-low, a..g): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 B=1100000 C=0110001 D=1000010 E=0110000 F=0111000.

Reset
REQ-025 rst SHALL force immediately, mid-operation included: state SEARCH, ref 0x00, match_cnt 0, miss_cnt 0, err_cnt 0x00, locked 0, err_pulse 0, seg_lo = seg_hi = 0000001.
REQ-026 The first valid word after rst deassertion SHALL be treated as a SEARCH seed.

Structure
REQ-027 A shared package SHALL hold the state enum, the tap mask (bits 0,2,3,4), the zero-state substitute 0x01, and the 16-entry segment table.
REQ-028 The hex-to-segment conversion SHALL be a sub-module seg7_decode, instantiated twice.

Verification
REQ-029 Reset; feed 0x01,0x80,0x40,0x20,0x10 -> locked=1 one cycle after 0x10, err_cnt=0, seg_lo=seg_hi=0000001.
REQ-030 Locked; feed 0x00 in place of 0x88, then 0xC4 -> err_pulse once, err_cnt=1, locked stays 1, seg_lo=1001111.
REQ-031 Locked; 3 consecutive wrong words -> err_cnt=3, locked=0 the cycle after the third; next valid word reseeds.
REQ-032 Locked; 260 mismatches with LOSS_COUNT overridden to 300 -> err_cnt=0xFF, seg_hi=seg_lo=0111000.
REQ-033 err_cnt=5; clr_err coincident with mismatch -> err_cnt=0, err_pulse=1.
REQ-034 Locked, err_cnt=2; assert rst between edges -> locked=0 and err_cnt=0 before next clk edge.

Source files
------------

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the LFSR stream checker: sync states, generator taps, segment table.
// Combinational helpers only; no latency or backpressure of their own.
package lfsr_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] TAP_MASK = 8'b0001_1101;
  localparam logic [7:0] ZERO_SUB = 8'h01;

  // Active-low, bit6..0 = a..g, indexed by hex digit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // All-zero is the lock-up state of this generator, so it is replaced by ZERO_SUB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    if (x == 8'h00) return ZERO_SUB;
    return {^(x & TAP_MASK), x[7:1]};
  endfunction

endpackage

// File: rtl/lfsr_checker_seg7_decode.sv
// Hex digit to active-low 7-segment pattern (a..g on bits 6..0).
// Purely combinational; no backpressure.
module seg7_decode
  import lfsr_checker_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/lfsr_checker.sv
// Locks onto an 8-bit LFSR word stream and counts mismatches once locked.
// Status registered one cycle after each accepted word; segments combinational; no backpressure.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       clr_err,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  state_t        state;
  logic [7:0]    ref_q;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;
  logic [7:0]    exp_word;

  assign exp_word = lfsr_next(ref_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SEARCH;
      ref_q     <= 8'h00;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_cnt   <= 8'h00;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_SEARCH: begin
            ref_q     <= in_data;
            match_cnt <= '0;
            state     <= ST_SYNC;
          end
          ST_SYNC: begin
            ref_q <= in_data;
            if (in_data == exp_word) begin
              if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                state     <= ST_LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-run the reference so a single bad word costs exactly one error.
            ref_q <= exp_word;
            if (in_data == exp_word) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
                state    <= ST_SEARCH;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
      if (clr_err) err_cnt <= 8'h00;
    end
  end

  seg7_decode u_seg_lo (.hex(err_cnt[3:0]), .seg(seg_lo));
  seg7_decode u_seg_hi (.hex(err_cnt[7:4]), .seg(seg_hi));

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: vector table for lock/single-error flow, hand sequences for corners.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clr_err = 1'b0;

  logic       locked, err_pulse;
  logic [7:0] err_cnt;
  logic [6:0] seg_lo, seg_hi;
  logic       locked2, err_pulse2;
  logic [7:0] err_cnt2;
  logic [6:0] seg_lo2, seg_hi2;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_ref;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] SF = 7'b0111000;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .seg_lo(seg_lo), .seg_hi(seg_hi)
  );

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(300)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .seg_lo(seg_lo2), .seg_hi(seg_hi2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       clr;
    logic       e_locked;
    logic       e_pulse;
    logic [7:0] e_cnt;
    logic [6:0] e_seg_lo;
    logic [6:0] e_seg_hi;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [7:0] tb_next(input logic [7:0] x);
    if (x == 8'h00) return 8'h01;
    return {x[0] ^ x[2] ^ x[3] ^ x[4], x[7:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    clr_err  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic lock_on(input logic [7:0] seed);
    exp_ref = seed;
    send(seed, 1'b0);
    repeat (4) begin
      exp_ref = tb_next(exp_ref);
      send(exp_ref, 1'b0);
    end
  endtask

  task automatic send_good();
    exp_ref = tb_next(exp_ref);
    send(exp_ref, 1'b0);
  endtask

  task automatic send_bad(input logic c);
    exp_ref = tb_next(exp_ref);
    send(8'h00, c);
  endtask

  initial begin
    // Lock on 01,80,40,20,10; then a single corrupted word in place of 88.
    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, S0, S0};
    vecs[1] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, S0, S0};
    vecs[2] = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, S0, S0};
    vecs[3] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, S0, S0};
    vecs[4] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, S0, S0};
    vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, S0, S0};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, S1, S0};
    vecs[7] = '{1'b1, 8'hC4, 1'b0, 1'b1, 1'b0, 8'h01, S1, S0};
    vecs[8] = '{1'b1, 8'hE2, 1'b0, 1'b1, 1'b0, 8'h01, S1, S0};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, S0, S0};

    // Reset state, checked while rst is still held.
    #1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_pulse", err_pulse, 1'b0);
    chk("rst_cnt", err_cnt, 8'h00);
    chk("rst_seg_lo", seg_lo, S0);
    chk("rst_seg_hi", seg_hi, S0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      clr_err  = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_locked", i), locked, vecs[i].e_locked);
      chk($sformatf("vec%0d_pulse", i), err_pulse, vecs[i].e_pulse);
      chk($sformatf("vec%0d_cnt", i), err_cnt, vecs[i].e_cnt);
      chk($sformatf("vec%0d_seg_lo", i), seg_lo, vecs[i].e_seg_lo);
      chk($sformatf("vec%0d_seg_hi", i), seg_hi, vecs[i].e_seg_hi);
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;

    // Three consecutive bad words drop lock; next word is a fresh seed.
    do_reset();
    lock_on(8'h01);
    chk("loss_pre_locked", locked, 1'b1);
    send_bad(1'b0);
    chk("loss1_locked", locked, 1'b1);
    chk("loss1_pulse", err_pulse, 1'b1);
    send_bad(1'b0);
    chk("loss2_locked", locked, 1'b1);
    send_bad(1'b0);
    chk("loss3_locked", locked, 1'b0);
    chk("loss3_cnt", err_cnt, 8'h03);
    chk("loss3_seg_lo", seg_lo, S3);
    lock_on(8'h05);
    chk("reseed_locked", locked, 1'b1);
    chk("reseed_cnt", err_cnt, 8'h03);

    // Reach err_cnt=5 with interleaved good words, then clear against a mismatch.
    do_reset();
    lock_on(8'h01);
    repeat (5) begin
      send_bad(1'b0);
      send_good();
    end
    chk("five_cnt", err_cnt, 8'h05);
    send_bad(1'b1);
    chk("clrmiss_cnt", err_cnt, 8'h00);
    chk("clrmiss_pulse", err_pulse, 1'b1);
    chk("clrmiss_locked", locked, 1'b1);
    @(posedge clk);
    #1;
    chk("idle_pulse_drop", err_pulse, 1'b0);

    // Asynchronous reset between edges clears status before the next edge.
    do_reset();
    lock_on(8'h01);
    send_bad(1'b0);
    send_bad(1'b0);
    chk("pre_arst_cnt", err_cnt, 8'h02);
    chk("pre_arst_locked", locked, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_locked", locked, 1'b0);
    chk("arst_cnt", err_cnt, 8'h00);
    chk("arst_pulse", err_pulse, 1'b0);
    chk("arst_seg_lo", seg_lo, S0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ref = 8'h33;
    send(8'h33, 1'b0);
    repeat (3) begin
      exp_ref = tb_next(exp_ref);
      send(exp_ref, 1'b0);
    end
    chk("postrst_not_yet", locked, 1'b0);
    exp_ref = tb_next(exp_ref);
    send(exp_ref, 1'b0);
    chk("postrst_locked", locked, 1'b1);

    // Saturation on the LOSS_COUNT=300 instance.
    do_reset();
    lock_on(8'h01);
    chk("sat_pre_locked", locked2, 1'b1);
    repeat (254) send_bad(1'b0);
    chk("sat_254", err_cnt2, 8'hFE);
    send_bad(1'b0);
    chk("sat_255", err_cnt2, 8'hFF);
    repeat (5) send_bad(1'b0);
    chk("sat_260_cnt", err_cnt2, 8'hFF);
    chk("sat_260_pulse", err_pulse2, 1'b1);
    chk("sat_260_locked", locked2, 1'b1);
    chk("sat_seg_lo", seg_lo2, SF);
    chk("sat_seg_hi", seg_hi2, SF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
